// File: rtl/fruit_lane_gen.sv
// fruit_lane_gen: round generator for the fruit-slicing game.
// Spawns up to three falling fruits per round, moves them down at a
// level-dependent speed, latches slices inside the hit window, then strobes
// chk until the control block completes its rs respawn handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   on                  game enable (0 = synchronous clear)
//   level[1:0]          current level (lane enables at spawn, speed per tick)
//   go                  game over, forces IDLE
//   rs1..rs3            respawn handshake from the control block
//   cut[2:0]            per-lane slice sensors (bit 0 = lane 1)
//   ac1..ac3, d1..d3    lane active / lane sliced flags for this round
//   chk                 round-check strobe
//   y1..y3[9:0]         fruit rows, 0 for inactive lanes
module fruit_lane_gen #(
  parameter int unsigned Y_MAX      = 479,
  parameter int unsigned HIT_LO     = 320,
  parameter int unsigned HIT_HI     = 440,
  parameter int unsigned TICK_DIV   = 416666,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter int unsigned MAX_PULSES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       on,
  input  logic [1:0] level,
  input  logic       go,
  input  logic       rs1,
  input  logic       rs2,
  input  logic       rs3,
  input  logic [2:0] cut,
  output logic       ac1,
  output logic       ac2,
  output logic       ac3,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       chk,
  output logic [9:0] y1,
  output logic [9:0] y2,
  output logic [9:0] y3
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned PW = $clog2(MAX_PULSES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FALL,
    S_PULSE,
    S_LOW,
    S_EVAL
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_lfsr;
  logic [TW-1:0]   r_tick_cnt;
  logic [PW-1:0]   r_pulse_cnt;
  logic [1:0]      r_low_cnt;
  logic            r_rs_seen;
  logic [2:0]      r_ac;
  logic [2:0]      r_d;
  logic [9:0]      r_y [3];

  logic            w_tick;
  logic            w_rs_any;
  logic [2:0]      w_speed;
  logic [2:0]      w_spawn_ac;
  logic [2:0]      w_in_win;
  logic [2:0]      w_at_max;
  logic            w_all_bottom;
  logic [10:0]     w_sum    [3];
  logic [9:0]      w_y_next [3];

  assign w_tick   = (r_state == S_FALL) && (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_rs_any = rs1 | rs2 | rs3;
  assign w_speed  = {1'b0, level} + 3'd1;

  // Lane enables from the LFSR; an empty pattern always falls back to lane 1.
  always_comb begin
    w_spawn_ac = 3'b001;
    case (level)
      2'd0:    w_spawn_ac = 3'b001;
      2'd1:    w_spawn_ac = {1'b0, r_lfsr[1:0]};
      default: w_spawn_ac = r_lfsr[2:0];
    endcase
    if (w_spawn_ac == 3'b000) w_spawn_ac = 3'b001;
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      w_sum[i]    = {1'b0, r_y[i]} + {8'd0, w_speed};
      w_y_next[i] = (w_sum[i] > 11'(Y_MAX)) ? 10'(Y_MAX) : w_sum[i][9:0];
      w_in_win[i] = (r_y[i] >= 10'(HIT_LO)) && (r_y[i] <= 10'(HIT_HI));
      w_at_max[i] = (r_y[i] == 10'(Y_MAX));
    end
  end

  // Inactive lanes count as already at the bottom.
  assign w_all_bottom = &(~r_ac | w_at_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= S_IDLE;
    else if (!on) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (on && !go) w_next = S_SPAWN;
      S_SPAWN: w_next = S_FALL;
      S_FALL:  if (w_all_bottom) w_next = S_PULSE;
      S_PULSE: w_next = S_LOW;
      S_LOW:   if (r_low_cnt == 2'd2) w_next = S_EVAL;
      S_EVAL: begin
        if (r_rs_seen && !w_rs_any)                 w_next = S_SPAWN;
        else if (r_pulse_cnt == PW'(MAX_PULSES))    w_next = S_SPAWN;
        else                                        w_next = S_PULSE;
      end
      default: w_next = S_IDLE;
    endcase
    if (go) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= LFSR_SEED;
      r_tick_cnt  <= '0;
      r_pulse_cnt <= '0;
      r_low_cnt   <= '0;
      r_rs_seen   <= 1'b0;
      r_ac        <= '0;
      r_d         <= '0;
      for (int unsigned i = 0; i < 3; i++) r_y[i] <= '0;
    end else if (!on) begin
      r_lfsr      <= LFSR_SEED;
      r_tick_cnt  <= '0;
      r_pulse_cnt <= '0;
      r_low_cnt   <= '0;
      r_rs_seen   <= 1'b0;
      r_ac        <= '0;
      r_d         <= '0;
      for (int unsigned i = 0; i < 3; i++) r_y[i] <= '0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

      // Held at zero outside FALL, so every FALL starts from a fresh count.
      if (r_state == S_FALL) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      else                   r_tick_cnt <= '0;

      case (r_state)
        S_SPAWN: begin
          r_ac        <= w_spawn_ac;
          r_d         <= '0;
          r_pulse_cnt <= '0;
          r_rs_seen   <= 1'b0;
          for (int unsigned i = 0; i < 3; i++) r_y[i] <= '0;
        end
        S_FALL: begin
          for (int unsigned i = 0; i < 3; i++) begin
            if (r_ac[i]) begin
              if (w_tick) r_y[i] <= w_y_next[i];
              if (cut[i] && w_in_win[i]) r_d[i] <= 1'b1;
            end
          end
        end
        S_PULSE: begin
          r_pulse_cnt <= r_pulse_cnt + PW'(1);
          r_low_cnt   <= '0;
        end
        S_LOW: begin
          r_low_cnt <= r_low_cnt + 2'd1;
          if (w_rs_any) r_rs_seen <= 1'b1;
        end
        S_EVAL: begin
          if (w_rs_any) r_rs_seen <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign {ac3, ac2, ac1} = r_ac;
  assign {d3, d2, d1}    = r_d;
  assign chk             = (r_state == S_PULSE);
  assign y1              = r_y[0];
  assign y2              = r_y[1];
  assign y3              = r_y[2];

endmodule

// File: tb/tb_fruit_lane_gen.sv
// Bench for fruit_lane_gen: timeline-driven stimulus with a round-level
// reference model (closed-form fall positions, slice window rule, pulse
// counts from the handshake plan) and a chk-edge scoreboard monitor.
module tb_fruit_lane_gen;

  localparam int YMAX = 479;
  localparam int HLO  = 320;
  localparam int HHI  = 440;
  localparam int TDIV = 4;

  logic       clk;
  logic       rst_n;
  logic       on;
  logic [1:0] level;
  logic       go;
  logic       rs1, rs2, rs3;
  logic [2:0] cut;
  logic       ac1, ac2, ac3, d1, d2, d3, chk;
  logic [9:0] y1, y2, y3;

  typedef struct packed {
    logic [2:0] ac;
    logic [2:0] d;
    logic [9:0] y1;
    logic [9:0] y2;
    logic [9:0] y3;
    logic       chk;
  } snap_t;

  int    checks      = 0;
  int    errors      = 0;
  int    pulses_seen = 0;
  int    exp_pulses  = 0;
  snap_t q[$];
  logic [7:0] m_lfsr;

  fruit_lane_gen #(.TICK_DIV(TDIV)) dut (
    .clk(clk), .rst_n(rst_n), .on(on), .level(level), .go(go),
    .rs1(rs1), .rs2(rs2), .rs3(rs3), .cut(cut),
    .ac1(ac1), .ac2(ac2), .ac3(ac3), .d1(d1), .d2(d2), .d3(d3),
    .chk(chk), .y1(y1), .y2(y2), .y3(y3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lstep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR: seed while held off, one step per enabled clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   m_lfsr <= 8'hA5;
    else if (!on) m_lfsr <= 8'hA5;
    else          m_lfsr <= lstep(m_lfsr);
  end

  function automatic logic [2:0] exp_ac(input int lvl, input logic [7:0] l);
    logic [2:0] a;
    if (lvl == 0)      a = 3'b001;
    else if (lvl == 1) a = {1'b0, l[1:0]};
    else               a = l[2:0];
    if (a == 3'b000) a = 3'b001;
    return a;
  endfunction

  function automatic snap_t mk(input logic [2:0] a, input logic [2:0] dd, input int yv, input logic c);
    snap_t s;
    s.ac  = a;
    s.d   = dd;
    s.y1  = a[0] ? 10'(yv) : 10'd0;
    s.y2  = a[1] ? 10'(yv) : 10'd0;
    s.y3  = a[2] ? 10'(yv) : 10'd0;
    s.chk = c;
    return s;
  endfunction

  function automatic snap_t get_snap();
    snap_t s;
    s.ac  = {ac3, ac2, ac1};
    s.d   = {d3, d2, d1};
    s.y1  = y1;
    s.y2  = y2;
    s.y3  = y3;
    s.chk = chk;
    return s;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one expected snapshot per chk rising edge.
  initial begin : monitor
    logic  chk_q;
    snap_t e;
    chk_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk_q = 1'b0;
      end else begin
        if (chk_q) check("chk_one_cycle", 64'(chk), 64'(0));
        if (chk && !chk_q) begin
          pulses_seen++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_chk at %0t: got pulse expected none", $time);
          end else begin
            e = q.pop_front();
            check("chk_scoreboard", 64'(get_snap()), 64'(e));
          end
        end
        chk_q = chk;
      end
    end
  end

  // Entered in the SPAWN cycle. k=0: rs held low (timeout); k>0: rs raised
  // at LOW/EVAL slot raise_j after pulse k, held through slot drop_j of
  // pulse k+1. Ends in the next SPAWN cycle, or in IDLE when go_end is set.
  task automatic run_round(input int lvl, input int k, input int per_mille, input bit directed_cut,
                           input int abort_at, input bit go_end, input int raise_j, input int drop_j);
    logic [2:0] a, dd;
    int speed, flen, npulse, yv, lane;
    bit hit_done, rs_v;
    snap_t e;
    level    = 2'(lvl);
    a        = exp_ac(lvl, m_lfsr);
    speed    = lvl + 1;
    flen     = TDIV * ((YMAX + speed - 1) / speed) + 1;
    dd       = '0;
    hit_done = 1'b0;
    lane     = $urandom_range(0, 2);
    next_cyc();
    for (int t = 0; t < flen; t++) begin
      yv = (t / TDIV) * speed;
      if (yv > YMAX) yv = YMAX;
      check("fall", 64'(get_snap()), 64'(mk(a, dd, yv, 1'b0)));
      if (directed_cut) begin
        cut = '0;
        if (yv == HLO - 1) cut[0] = 1'b1;
        else if (yv == HLO && !hit_done) begin
          cut[0]   = 1'b1;
          hit_done = 1'b1;
        end
      end else begin
        for (int i = 0; i < 3; i++) cut[i] = ($urandom_range(0, 999) < per_mille);
      end
      for (int i = 0; i < 3; i++)
        if (cut[i] && a[i] && yv >= HLO && yv <= HHI) dd[i] = 1'b1;
      if (abort_at == t) begin
        #2 rst_n = 1'b0;
        #1 check("async_reset", 64'(get_snap()), 64'(0));
        cut = '0;
        #2 rst_n = 1'b1;
        return;
      end
      next_cyc();
    end
    cut    = '0;
    npulse = (k == 0) ? 6 : k + 1;
    e      = mk(a, dd, YMAX, 1'b1);
    for (int p = 0; p < npulse; p++) q.push_back(e);
    exp_pulses += npulse;
    for (int p = 1; p <= npulse; p++) begin
      for (int j = 0; j < 5; j++) begin
        rs_v = (k != 0) && ((p == k && j >= raise_j) || (p == k + 1 && j <= drop_j));
        {rs3, rs2, rs1} = rs_v ? (3'b001 << lane) : 3'b000;
        if (go_end && p == npulse && j == 1) go = 1'b1;
        check("pulse_phase", 64'(get_snap()), 64'(mk(a, dd, YMAX, (j == 0))));
        next_cyc();
        if (go_end && p == npulse && j == 1) begin
          {rs3, rs2, rs1} = 3'b000;
          for (int h = 0; h < 5; h++) begin
            check("gameover_hold", 64'(get_snap()), 64'(mk(a, dd, YMAX, 1'b0)));
            next_cyc();
          end
          return;
        end
      end
    end
    {rs3, rs2, rs1} = 3'b000;
  endtask

  // From IDLE with go held: release go so the spawn lands on a wanted LFSR pattern.
  task automatic spawn_when(input bit use_tgt, input logic [2:0] tgt, input int lvl);
    logic [7:0] nxt;
    level = 2'(lvl);
    for (int i = 0; i < 600; i++) begin
      nxt = lstep(m_lfsr);
      if (!use_tgt || nxt[2:0] == tgt) begin
        go = 1'b0;
        next_cyc();
        return;
      end
      next_cyc();
    end
    checks++;
    errors++;
    $display("FAIL spawn_wait: got no lfsr match in 600 cycles expected %b", tgt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin : stim
    int lv, kk, pm;
    rst_n = 1'b0; on = 1'b0; go = 1'b0; level = 2'd0;
    rs1 = 1'b0; rs2 = 1'b0; rs3 = 1'b0; cut = '0;
    next_cyc();
    next_cyc();
    check("reset_state", 64'(get_snap()), 64'(0));
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      check("off_idle", 64'(get_snap()), 64'(0));
    end

    on = 1'b1;
    next_cyc();
    run_round(0, 0, 5, 1'b0, 50, 1'b0, 1, 0);
    next_cyc();

    run_round(0, 2, 0, 1'b1, -1, 1'b0, 1, 0);
    run_round(1, 0, 10, 1'b0, -1, 1'b0, 1, 0);
    for (int r = 0; r < 6; r++) begin
      lv = $urandom_range(0, 3);
      kk = $urandom_range(0, 4);
      case ($urandom_range(0, 2))
        0:       pm = 0;
        1:       pm = 3;
        default: pm = 15;
      endcase
      run_round(lv, kk, pm, 1'b0, -1, 1'b0, $urandom_range(1, 4), $urandom_range(0, 3));
    end
    run_round(3, 1, 10, 1'b0, -1, 1'b1, 2, 1);

    spawn_when(1'b1, 3'b101, 2);
    run_round(2, 3, 10, 1'b0, -1, 1'b1, 1, 2);

    on = 1'b0;
    next_cyc();
    check("on_clear", 64'(get_snap()), 64'(0));
    go = 1'b0;
    next_cyc();
    check("on_clear_hold", 64'(get_snap()), 64'(0));
    repeat (4) next_cyc();
    check("queue_empty", 64'(q.size()), 64'(0));
    check("pulse_total", 64'(pulses_seen), 64'(exp_pulses));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
